// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared matmul types: accumulator width helper, element type, drain FSM states
package matmul_pkg;

    function automatic int acc_width(input int data_width, input int m);
        return 2 * data_width + $clog2(m);
    endfunction

    localparam int DEF_ACC_WIDTH = acc_width(16, 32);

    typedef logic signed [DEF_ACC_WIDTH-1:0] acc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_e;

endpackage

// File: rtl/sat_narrow.sv
// rtl/sat_narrow.sv - combinational signed saturating narrow from IN_W to OUT_W with clip indication
module sat_narrow #(
    parameter int IN_W  = 34,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  in_data,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    clip
);

    generate
        if (OUT_W == IN_W) begin : g_pass
            assign out_data = in_data;
            assign clip     = 1'b0;
        end else begin : g_sat
            localparam int HW = IN_W - OUT_W + 1;
            logic [HW-1:0] head;

            // The value fits only if every bit from the new sign position upward matches.
            assign head = in_data[IN_W-1:OUT_W-1];
            assign clip = !((&head) || !(|head));

            always_comb begin
                if (!clip) begin
                    out_data = in_data[OUT_W-1:0];
                end else if (in_data[IN_W-1]) begin
                    out_data = {1'b1, {(OUT_W-1){1'b0}}};
                end else begin
                    out_data = {1'b0, {(OUT_W-1){1'b1}}};
                end
            end
        end
    endgenerate

endmodule

// File: rtl/matmul_out_stream.sv
// rtl/matmul_out_stream.sv - snapshots an NxQ accumulator matrix and drains it as a saturated row-major stream
module matmul_out_stream
    import matmul_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  N          = 32,
    parameter int  M          = 32,
    parameter int  Q          = 32,
    parameter int  OUT_WIDTH  = DATA_WIDTH,
    localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, M)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic signed [ACC_WIDTH-1:0] mat_in [N][Q],
    output logic                        busy,
    output logic                        done,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_row_last,
    output logic                        out_last,
    output logic                        sat_flag
);

    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
    localparam int COL_W = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(Q - 1);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_STREAM = STREAM;
    localparam logic [1:0] ST_FLUSH  = FLUSH;

    logic [1:0]       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             sat_q, sat_d;
    logic signed [ACC_WIDTH-1:0] snap_q [N][Q];
    logic signed [ACC_WIDTH-1:0] snap_d [N][Q];

    logic signed [ACC_WIDTH-1:0] sel_elem;
    logic signed [OUT_WIDTH-1:0] sat_data;
    logic                        sel_clip;

    assign sel_elem = snap_q[row_q][col_q];

    sat_narrow #(
        .IN_W  (ACC_WIDTH),
        .OUT_W (OUT_WIDTH)
    ) u_sat (
        .in_data  (sel_elem),
        .out_data (sat_data),
        .clip     (sel_clip)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        sat_d   = sat_q;
        snap_d  = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    snap_d  = mat_in;
                    row_d   = '0;
                    col_d   = '0;
                    sat_d   = 1'b0;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (out_ready) begin
                    if (sel_clip) begin
                        sat_d = 1'b1;
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = ST_FLUSH;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            sat_q   <= sat_d;
        end
    end

    // Snapshot contents are don't-care after reset, so they carry no reset.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign out_valid    = (state_q == ST_STREAM);
    assign busy         = out_valid;
    assign done         = (state_q == ST_FLUSH);
    assign out_data     = out_valid ? sat_data : '0;
    assign out_row_last = out_valid && (col_q == COL_LAST);
    assign out_last     = out_row_last && (row_q == ROW_LAST);
    assign sat_flag     = sat_q;

endmodule

// File: doc/matmul_out_stream.md
# matmul_out_stream

Downstream drain for the matrix-multiply engine: snapshots a completed N×Q result matrix of wide signed accumulators and emits it as a row-major valid/ready element stream. Each accumulator is saturated to OUT_WIDTH on the way out. Row-end and matrix-end markers let the consumer (DMA or writeback) frame the data without extra counters.

## Interface
- DATA_WIDTH, 16, operand element width; sets the accumulator width.
- N, 32, result rows.
- M, 32, inner dimension; sets accumulator growth.
- Q, 32, result columns.
- OUT_WIDTH, DATA_WIDTH, emitted element width; must be ≤ ACC_WIDTH.
- ACC_WIDTH (derived, not overridable): 2*DATA_WIDTH + $clog2(M).
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to capture mat_in and begin streaming.
- mat_in  in  signed ACC_WIDTH [N][Q]  result matrix; sampled only on an accepted start.
- busy  out  1  high from the cycle after an accepted start until the final handshake completes.
- done  out  1  one-cycle pulse the cycle after the final handshake.
- out_valid  out  1  element on out_data is valid.
- out_ready  in  1  consumer accepts the element this cycle.
- out_data  out  signed OUT_WIDTH  saturated element.
- out_row_last  out  1  element is the last of its row (col == Q-1).
- out_last  out  1  element is the last of the matrix (row N-1, col Q-1).
- sat_flag  out  1  sticky; set if any element of the current matrix clipped.

## Operation
- FSM states:
  - IDLE: waits for start.
  - STREAM: presents elements.
  - FLUSH: one cycle; pulses done, then returns to IDLE.
- IDLE, start=1: capture all of mat_in into a snapshot buffer, set row=col=0, clear sat_flag, go to STREAM.
- start while busy or in FLUSH is ignored: no recapture, no restart.
- STREAM:
  - out_data = sat(snap[row][col]).
  - Handshake when out_valid && out_ready: advance col. At col == Q-1, wrap col to 0 and increment row.
  - Handshake with out_last=1: go to FLUSH.
- Saturation:
  - v > 2^(OUT_WIDTH-1)-1 → 2^(OUT_WIDTH-1)-1.
  - v < -2^(OUT_WIDTH-1) → -2^(OUT_WIDTH-1).
  - Otherwise truncate to the low OUT_WIDTH bits. When OUT_WIDTH == ACC_WIDTH this is a pass-through.
- sat_flag is set when a clipped element is handshaken, and holds until the next accepted start.
- The snapshot decouples this block from mat_in. Upstream may start computing the next matrix immediately after start is accepted.

## Timing
- Reset values: out_valid=0, out_data=0, out_row_last=0, out_last=0, busy=0, done=0, sat_flag=0, FSM=IDLE, row=col=0. The snapshot contents are don't-care.
- Start accepted at edge t: at t+1, out_valid=1 with element [0][0] and busy=1.
- Throughput is one element per cycle with out_ready held high. Total N*Q cycles from the first out_valid to the final handshake.
- With out_valid=1 and out_ready=0, out_data, out_row_last and out_last hold stable. out_valid never drops until the handshake.
- Final handshake at edge u: at u+1, out_valid=0, busy=0, done=1. At u+2, done=0, FSM=IDLE, and a new start is accepted.
- out_ready is ignored while out_valid=0.
- Reset asserted mid-stream: at the next edge, all outputs return to reset values. The partial stream is abandoned with no done pulse.
- start and reset high together: reset wins.
- Degenerate N=1 or Q=1: out_row_last / out_last still follow the equations above. With N=Q=1, the single element carries both markers.

## Structure
- Shared package matmul_pkg (also used by the engine):
  - localparam-style function acc_width(DATA_WIDTH, M).
  - typedef for the accumulator element.
  - State enum {IDLE, STREAM, FLUSH}.
- Sub-module sat_narrow #(IN_W, OUT_W): purely combinational saturating narrow; outputs the result and a clip bit. Instantiated once on the selected snapshot element.
- Element select is a row/col-indexed mux on the snapshot. No extra output register stage beyond the registered row/col/state.

## Test plan
- Identity stream, DATA_WIDTH=16, OUT_WIDTH=16, N=Q=M=4: mat_in[i][j]=i*4+j, start, out_ready=1 → 16 beats with values 0..15 in order.
  - out_row_last on beats 3, 7, 11, 15; out_last only on beat 15.
  - done exactly one cycle later; sat_flag=0.
- Saturation: elements 40000, -40000, 32767, -32768 → 32767, -32768, 32767, -32768; sat_flag=1 after beat 1 and held.
- Backpressure: out_ready toggled by pseudo-random 50% pattern → out_data stable across stalls, no drops or duplicates, order 0..15 preserved.
- Start while busy: second start mid-stream with a different mat_in → ignored; the original 16 values complete and a single done pulses.
- Reset mid-stream after 5 beats → next cycle out_valid=0, busy=0, no done. A fresh start streams from [0][0].
- Snapshot isolation: change mat_in every cycle after start → emitted values equal those present at the start edge.
